// File: rtl/arc4_pkg.sv
// Shared types and widths for the ARC4 decryption datapath.
package arc4_pkg;

    localparam int unsigned S_ADDR_W = 8;
    localparam int unsigned S_DATA_W = 8;
    localparam int unsigned KEY_W    = 24;

    typedef enum logic [3:0] {
        StIdle,
        StInitGo,
        StInitBusy,
        StInitDone,
        StKsaGo,
        StKsaBusy,
        StKsaDone,
        StPrgaGo,
        StPrgaBusy,
        StPrgaDone
    } state_e;

    typedef enum logic [1:0] {
        OwnerNone,
        OwnerInit,
        OwnerKsa,
        OwnerPrga
    } owner_e;

endpackage

// File: rtl/arc4_sched_if.sv
// Host handshake, sub-block handshakes and S-memory request/port bundle of arc4_sched.
interface arc4_sched_if;
    import arc4_pkg::*;

    logic                en;
    logic                rdy;
    logic [KEY_W-1:0]    key;
    logic                err;
    logic [KEY_W-1:0]    key_out;

    logic                init_en,  ksa_en,  prga_en;
    logic                init_rdy, ksa_rdy, prga_rdy;

    logic [S_ADDR_W-1:0] init_s_addr,   ksa_s_addr,   prga_s_addr;
    logic [S_DATA_W-1:0] init_s_wrdata, ksa_s_wrdata, prga_s_wrdata;
    logic                init_s_wren,   ksa_s_wren,   prga_s_wren;

    logic [S_ADDR_W-1:0] s_addr;
    logic [S_DATA_W-1:0] s_wrdata;
    logic                s_wren;

    modport slave (
        input  en, key, init_rdy, ksa_rdy, prga_rdy,
               init_s_addr, ksa_s_addr, prga_s_addr,
               init_s_wrdata, ksa_s_wrdata, prga_s_wrdata,
               init_s_wren, ksa_s_wren, prga_s_wren,
        output rdy, err, key_out, init_en, ksa_en, prga_en,
               s_addr, s_wrdata, s_wren
    );

    modport master (
        output en, key, init_rdy, ksa_rdy, prga_rdy,
               init_s_addr, ksa_s_addr, prga_s_addr,
               init_s_wrdata, ksa_s_wrdata, prga_s_wrdata,
               init_s_wren, ksa_s_wren, prga_s_wren,
        input  rdy, err, key_out, init_en, ksa_en, prga_en,
               s_addr, s_wrdata, s_wren
    );

endinterface

// File: rtl/s_port_mux.sv
// 3:1 S-memory request mux selected by the registered owner; no owner drives all zeros.
module s_port_mux
    import arc4_pkg::*;
(
    input  owner_e              owner,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [S_DATA_W-1:0] init_wrdata,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] ksa_addr,
    input  logic [S_DATA_W-1:0] ksa_wrdata,
    input  logic                ksa_wren,
    input  logic [S_ADDR_W-1:0] prga_addr,
    input  logic [S_DATA_W-1:0] prga_wrdata,
    input  logic                prga_wren,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [S_DATA_W-1:0] s_wrdata,
    output logic                s_wren
);

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        unique case (owner)
            OwnerInit: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            OwnerKsa: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            OwnerPrga: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 pass sequencer: runs init, KSA, then PRGA, owns the shared S-memory port and
// watchdogs every phase so a hung sub-block is reported instead of stalling the pass.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    arc4_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WdogMax  = '1;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             err_q, err_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             timeout;

    // Phase cycle k sees wdog_q == k, so the last allowed cycle is TIMEOUT_CYCLES-1.
    assign timeout = (state_q != StIdle) && (wdog_q >= WdogLast);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        err_d       = err_q;
        key_d       = key_q;
        wdog_d      = '0;
        bus.rdy     = 1'b0;
        bus.init_en = 1'b0;
        bus.ksa_en  = 1'b0;
        bus.prga_en = 1'b0;

        if (state_q != StIdle) begin
            wdog_d = (wdog_q == WdogMax) ? wdog_q : wdog_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                bus.rdy = 1'b1;
                if (bus.en) begin
                    key_d   = bus.key;
                    err_d   = 1'b0;
                    state_d = StInitGo;
                end
            end
            StInitGo: begin
                if (bus.init_rdy) begin
                    bus.init_en = 1'b1;
                    owner_d     = OwnerInit;
                    state_d     = StInitBusy;
                end
            end
            StInitBusy: if (!bus.init_rdy) state_d = StInitDone;
            StInitDone: begin
                if (bus.init_rdy) begin
                    state_d = StKsaGo;
                    wdog_d  = '0;
                end
            end
            StKsaGo: begin
                if (bus.ksa_rdy) begin
                    bus.ksa_en = 1'b1;
                    owner_d    = OwnerKsa;
                    state_d    = StKsaBusy;
                end
            end
            StKsaBusy: if (!bus.ksa_rdy) state_d = StKsaDone;
            StKsaDone: begin
                if (bus.ksa_rdy) begin
                    state_d = StPrgaGo;
                    wdog_d  = '0;
                end
            end
            StPrgaGo: begin
                if (bus.prga_rdy) begin
                    bus.prga_en = 1'b1;
                    owner_d     = OwnerPrga;
                    state_d     = StPrgaBusy;
                end
            end
            StPrgaBusy: if (!bus.prga_rdy) state_d = StPrgaDone;
            StPrgaDone: begin
                if (bus.prga_rdy) begin
                    owner_d = OwnerNone;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A timed-out phase is abandoned outright: no start pulse, no further hand-off.
        if (timeout) begin
            bus.init_en = 1'b0;
            bus.ksa_en  = 1'b0;
            bus.prga_en = 1'b0;
            owner_d     = OwnerNone;
            err_d       = 1'b1;
            state_d     = StIdle;
            wdog_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= OwnerNone;
            err_q   <= 1'b0;
            key_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            key_q   <= key_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus.err     = err_q;
    assign bus.key_out = key_q;

    s_port_mux u_s_port_mux (
        .owner       (owner_q),
        .init_addr   (bus.init_s_addr),
        .init_wrdata (bus.init_s_wrdata),
        .init_wren   (bus.init_s_wren),
        .ksa_addr    (bus.ksa_s_addr),
        .ksa_wrdata  (bus.ksa_s_wrdata),
        .ksa_wren    (bus.ksa_s_wren),
        .prga_addr   (bus.prga_s_addr),
        .prga_wrdata (bus.prga_s_wrdata),
        .prga_wren   (bus.prga_s_wren),
        .s_addr      (bus.s_addr),
        .s_wrdata    (bus.s_wrdata),
        .s_wren      (bus.s_wren)
    );

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Top-level sequencer for one ARC4 decryption pass: runs s-memory init, then key scheduling (KSA), then keystream generation/decrypt (PRGA), in that order.
- Owns the single S-memory port and grants it to exactly one sub-block at a time.
- Exposes one ready/enable handshake upward and drives ready/enable handshakes to the three sub-blocks.
- Adds a per-phase watchdog so a hung sub-block is reported instead of stalling forever.

Parameters:
- TIMEOUT_CYCLES, default 65536: maximum cycles one phase may stay busy before the error flag is raised.
- CNT_W, default 17: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- en  in  1  start request from the host; accepted only while rdy=1
- rdy  out  1  high when idle and able to accept en
- key  in  24  decryption key; sampled on the accepting edge
- err  out  1  sticky watchdog error; cleared by the next accepted en
- key_out  out  24  latched key, fed to KSA and PRGA
- init_en / ksa_en / prga_en  out  1 each  sub-block start pulses
- init_rdy / ksa_rdy / prga_rdy  in  1 each  sub-block ready flags
- init_s_addr, ksa_s_addr, prga_s_addr  in  8 each  per-requester S address
- init_s_wrdata, ksa_s_wrdata, prga_s_wrdata  in  8 each  per-requester S write data
- init_s_wren, ksa_s_wren, prga_s_wren  in  1 each  per-requester S write enable
- s_addr  out  8  to S memory
- s_wrdata  out  8  to S memory
- s_wren  out  1  to S memory
- Read data from S memory is not routed through this block; it is broadcast to all three sub-blocks.

Behaviour:
- Reset (async, active-low): state=IDLE, rdy=1, err=0, key_out=0, all *_en=0, owner=NONE, s_addr=0, s_wrdata=0, s_wren=0, watchdog=0.
- Handshake rule, upward and downward:
  - A start is a one-cycle en pulse, issued only while the target's rdy=1.
  - The target drops rdy after accepting.
  - The target is finished when its rdy returns to 1.
- States:
  - IDLE: rdy=1. On en=1, latch key into key_out, clear err, go to INIT_GO.
  - INIT_GO: if init_rdy=1, pulse init_en, set owner=INIT, go to INIT_BUSY. Otherwise hold.
  - INIT_BUSY: wait for init_rdy=0 (covers a sub-block that drops rdy one cycle late), then go to INIT_DONE.
  - INIT_DONE: wait for init_rdy=1, then go to KSA_GO.
  - KSA_GO, KSA_BUSY, KSA_DONE: identical pattern using ksa_* signals and owner=KSA.
  - PRGA_GO, PRGA_BUSY, PRGA_DONE: identical pattern using prga_* signals and owner=PRGA.
  - After PRGA_DONE, set owner=NONE and go to IDLE.
- rdy=0 in every state except IDLE. en pulses outside IDLE are ignored.
- Latency: exactly 1 cycle from en acceptance to init_en, when init_rdy=1. Between consecutive phases the overhead is 1 cycle (DONE→GO) plus 1 cycle for the en pulse.
- S-port mux (combinational on the registered owner):
  - s_addr, s_wrdata and s_wren follow the owner's inputs.
  - owner=NONE forces all three outputs to 0.
  - Non-owner wren is ignored, so no write is ever lost to or leaked from a non-owner.
  - owner changes only on *_en pulse cycles and on the final return to IDLE.
- Watchdog:
  - Cleared on entry to every GO state.
  - Increments each cycle in GO, BUSY and DONE states, saturating at its maximum.
  - On reaching TIMEOUT_CYCLES: set err=1, set owner=NONE, go to IDLE with no further phases.
  - err stays 1 until the next accepted en.
- key_out holds its value until the next accepted en; a change on key mid-operation has no effect.
- Reset mid-operation: everything returns to reset values immediately and s_wren=0 asynchronously. The next run starts from init.
- Simultaneous events: en held high across the return to IDLE is accepted in the IDLE cycle, which starts a new run.

Decomposition:
- Shared package arc4_pkg holds:
  - a state enum typedef
  - an owner typedef (NONE, INIT, KSA, PRGA)
  - S_ADDR_W=8, S_DATA_W=8, KEY_W=24
- One natural sub-module: s_port_mux, a 3:1 S-memory request mux selected by owner, with NONE forcing zeros.

Test Plan:
- Nominal run. Stimulus: stub sub-blocks with busy times 256, 768 and 1024 cycles; key=24'h000018; pulse en. Required response:
  - key_out=24'h000018.
  - Exactly one pulse each of init_en, ksa_en, prga_en, in that order.
  - rdy returns to 1 with err=0.
- Mux isolation. Stimulus: during each phase, drive distinct addr/wrdata/wren patterns on all three requesters (e.g. ksa addr=8'hA5, wren=1 while init wren=1). Required response: s_* always equals the owner's inputs, and never shows a non-owner's wren.
- Late-rdy stub. Stimulus: KSA stub keeps ksa_rdy high for 1 extra cycle after ksa_en. Required response: exactly one ksa_en, and PRGA does not start early.
- Timeout. Stimulus: PRGA stub never reasserts rdy; TIMEOUT_CYCLES=100. Required response:
  - err=1 and owner=NONE (s_wren=0) after 100 cycles, then rdy=1.
  - The next en clears err.
- Reset mid-KSA. Stimulus: assert rst_n=0 at cycle 300 while ksa_s_wren=1. Required response: s_wren=0 immediately, and rdy=1 and err=0 after release.
- Ignored en. Stimulus: pulse en with key=24'h123456 while in PRGA_BUSY. Required response: key_out unchanged, and no extra init_en.
